// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: one Moore-decoded step per clock,
// stalling in the memory states until mem_ready, with a one-cycle illegal-opcode pulse.
module mips_multicycle_ctrl (
   input  logic       clk,
   input  logic       clr,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic [3:0] state,
   output logic       illegal
);

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_J     = 6'b000010;
   localparam logic [5:0] OPC_ADDI  = 6'b001000;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_IMM_EXEC  = 4'd10,
      S_IMM_WB    = 4'd11
   } state_t;

   state_t cur_state;
   state_t next_state;

   always_ff @(posedge clk) begin
      if (clr)
         cur_state <= S_FETCH;
      else
         cur_state <= next_state;
   end

   // Outputs are pure state decode except the FETCH ir/pc loads and the illegal pulse;
   // clr overrides everything so an in-flight write is dropped in the same cycle.
   always_comb begin
      next_state    = cur_state;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      illegal       = 1'b0;

      case (cur_state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready)
               next_state = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OPC_LW, OPC_SW: next_state = S_MEM_ADDR;
               OPC_RTYPE:      next_state = S_EXECUTE;
               OPC_BEQ:        next_state = S_BRANCH;
               OPC_J:          next_state = S_JUMP;
               OPC_ADDI:       next_state = S_IMM_EXEC;
               default: begin
                  next_state = S_FETCH;
                  illegal    = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            // A corrupted opcode here abandons the access rather than guessing.
            if (opcode == OPC_LW)
               next_state = S_MEM_READ;
            else if (opcode == OPC_SW)
               next_state = S_MEM_WRITE;
            else
               next_state = S_FETCH;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready)
               next_state = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            next_state = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready)
               next_state = S_FETCH;
         end
         S_EXECUTE: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b10;
            next_state = S_R_WB;
         end
         S_R_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            next_state = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            next_state    = S_FETCH;
         end
         S_JUMP: begin
            pc_write   = 1'b1;
            pc_source  = 2'b10;
            next_state = S_FETCH;
         end
         S_IMM_EXEC: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            next_state = S_IMM_WB;
         end
         S_IMM_WB: begin
            reg_write  = 1'b1;
            next_state = S_FETCH;
         end
         default: next_state = S_FETCH;
      endcase

      if (clr) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         iord          = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         mem_to_reg    = 1'b0;
         reg_dst       = 1'b0;
         reg_write     = 1'b0;
         alu_src_a     = 1'b0;
         alu_src_b     = 2'b00;
         alu_op        = 2'b00;
         pc_source     = 2'b00;
         illegal       = 1'b0;
      end
   end

   assign state = clr ? 4'd0 : cur_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: each driven cycle queues the expected state,
// control vector and illegal flag; a negedge monitor pops and compares against the DUT.
module tb_mips_multicycle_ctrl;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_J     = 6'b000010;
   localparam logic [5:0] OPC_ADDI  = 6'b001000;
   localparam logic [5:0] OPC_BAD   = 6'b111111;

   logic       clk;
   logic       clr;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state;
   logic       illegal;

   typedef struct {
      string       tag;
      logic [3:0]  st;
      logic [15:0] outs;
      logic        ill;
   } expect_t;

   expect_t sb[$];
   int checks   = 0;
   int failures = 0;

   mips_multicycle_ctrl dut (
      .clk           (clk),
      .clr           (clr),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .iord          (iord),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .pc_source     (pc_source),
      .state         (state),
      .illegal       (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control vector layout shared by the expectation table and the monitor.
   function automatic logic [15:0] pack_outs(
      input logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa,
      input logic [1:0] asb, aop, psrc);
      return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc};
   endfunction

   // Expected Moore outputs for a state, straight from the control table.
   function automatic logic [15:0] table_outs(input logic [3:0] st, input logic mr);
      case (st)
         4'd0:  return pack_outs(mr, 0, 0, 1, 0, mr, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
         4'd1:  return pack_outs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
         4'd2:  return pack_outs(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
         4'd3:  return pack_outs(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
         4'd4:  return pack_outs(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00);
         4'd5:  return pack_outs(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
         4'd6:  return pack_outs(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00);
         4'd7:  return pack_outs(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00);
         4'd8:  return pack_outs(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
         4'd9:  return pack_outs(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10);
         4'd10: return pack_outs(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
         4'd11: return pack_outs(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
         default: return 16'h0000;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs and queue what the DUT must show before the next edge.
   task automatic applyStimulus(input string tag, input logic c, input logic [5:0] op,
                                input logic mr, input logic [3:0] exp_st,
                                input logic exp_ill);
      expect_t e;
      clr       = c;
      opcode    = op;
      mem_ready = mr;
      e.tag  = tag;
      e.st   = c ? 4'd0 : exp_st;
      e.outs = c ? 16'h0000 : table_outs(exp_st, mr);
      e.ill  = c ? 1'b0 : exp_ill;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      expect_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput({e.tag, "_state"}, {12'd0, state}, {12'd0, e.st});
         checkOutput({e.tag, "_ctrl"},
                     pack_outs(pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                               alu_op, pc_source),
                     e.outs);
         checkOutput({e.tag, "_illegal"}, {15'd0, illegal}, {15'd0, e.ill});
         checkOutput({e.tag, "_rd_wr_excl"}, {15'd0, mem_read & mem_write}, 16'h0000);
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      clr       = 1'b1;
      opcode    = OPC_LW;
      mem_ready = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus("rst0", 1, OPC_LW, 1, 4'd0, 0);
      applyStimulus("rst1", 1, OPC_LW, 1, 4'd0, 0);

      applyStimulus("lw_f",   0, OPC_LW, 1, 4'd0, 0);
      applyStimulus("lw_d",   0, OPC_LW, 1, 4'd1, 0);
      applyStimulus("lw_ma",  0, OPC_LW, 1, 4'd2, 0);
      applyStimulus("lw_mr",  0, OPC_LW, 1, 4'd3, 0);
      applyStimulus("lw_wb",  0, OPC_LW, 1, 4'd4, 0);

      applyStimulus("sw_f",   0, OPC_SW, 1, 4'd0, 0);
      applyStimulus("sw_d",   0, OPC_SW, 1, 4'd1, 0);
      applyStimulus("sw_ma",  0, OPC_SW, 1, 4'd2, 0);
      for (int i = 0; i < 3; i++)
         applyStimulus("sw_wait", 0, OPC_SW, 0, 4'd5, 0);
      applyStimulus("sw_done", 0, OPC_SW, 1, 4'd5, 0);

      applyStimulus("r_f",    0, OPC_RTYPE, 1, 4'd0, 0);
      applyStimulus("r_d",    0, OPC_RTYPE, 1, 4'd1, 0);
      applyStimulus("r_ex",   0, OPC_RTYPE, 1, 4'd6, 0);
      applyStimulus("r_wb",   0, OPC_RTYPE, 1, 4'd7, 0);

      applyStimulus("beq_f",  0, OPC_BEQ, 1, 4'd0, 0);
      applyStimulus("beq_d",  0, OPC_BEQ, 1, 4'd1, 0);
      applyStimulus("beq_br", 0, OPC_BEQ, 1, 4'd8, 0);

      applyStimulus("j_f",    0, OPC_J, 1, 4'd0, 0);
      applyStimulus("j_d",    0, OPC_J, 1, 4'd1, 0);
      applyStimulus("j_jmp",  0, OPC_J, 1, 4'd9, 0);

      applyStimulus("addi_f", 0, OPC_ADDI, 1, 4'd0, 0);
      applyStimulus("addi_d", 0, OPC_ADDI, 1, 4'd1, 0);
      applyStimulus("addi_ex",0, OPC_ADDI, 1, 4'd10, 0);
      applyStimulus("addi_wb",0, OPC_ADDI, 1, 4'd11, 0);

      applyStimulus("bad_f",  0, OPC_BAD, 1, 4'd0, 0);
      applyStimulus("bad_d",  0, OPC_BAD, 1, 4'd1, 1);

      // mem_ready ignored outside memory states; FETCH holds without ir/pc loads.
      applyStimulus("fw_hold0", 0, OPC_J, 0, 4'd0, 0);
      applyStimulus("fw_hold1", 0, OPC_J, 0, 4'd0, 0);
      applyStimulus("fw_go",    0, OPC_J, 1, 4'd0, 0);
      applyStimulus("fw_d",     0, OPC_J, 0, 4'd1, 0);
      applyStimulus("fw_jmp",   0, OPC_J, 0, 4'd9, 0);

      applyStimulus("ab_f",   0, OPC_SW, 1, 4'd0, 0);
      applyStimulus("ab_d",   0, OPC_SW, 1, 4'd1, 0);
      applyStimulus("ab_ma",  0, OPC_SW, 0, 4'd2, 0);
      applyStimulus("ab_mw",  0, OPC_SW, 0, 4'd5, 0);
      applyStimulus("ab_clr", 1, OPC_SW, 0, 4'd0, 0);
      applyStimulus("ab_f2",  0, OPC_SW, 0, 4'd0, 0);
      applyStimulus("ab_f3",  0, OPC_SW, 0, 4'd0, 0);

      @(negedge clk);
      checkOutput("sb_drained", 16'(sb.size()), 16'h0000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
